pc_counter_stack: RTL and testbench

- Parametrised next-generation program counter for the VeriRISC datapath.
- Extends the basic load/increment counter with:
  - a configurable increment step,
  - a hardware return-address stack (call/return) of DEPTH entries,
  - a registered wrap indication,
  - sticky stack overflow/underflow error flags.
- Sits between the controller and the instruction-address mux.
- Drives the fetch address every cycle.

---
 rtl/pc_counter_stack_if.sv | 31 +++
 rtl/pc_counter_stack.sv | 86 ++++++++
 tb/tb_pc_counter_stack.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pc_counter_stack_if.sv
// Controller-side bundle for the program counter: control/target inputs
// and the counter, stack-level and status outputs.
interface pc_counter_stack_if #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LVLW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] cnt_in;
   logic             enab;
   logic             load;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] cnt_out;
   logic [LVLW-1:0]  sp_level;
   logic             full;
   logic             empty;
   logic             wrapped;
   logic             ovf_err;
   logic             unf_err;

   modport master (
      output cnt_in, enab, load, call, ret,
      input  cnt_out, sp_level, full, empty, wrapped, ovf_err, unf_err
   );

   modport slave (
      input  cnt_in, enab, load, call, ret,
      output cnt_out, sp_level, full, empty, wrapped, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_counter_stack.sv
// Program counter with configurable step, call/return address stack,
// registered wrap pulse and sticky stack overflow/underflow flags.
module pc_counter_stack #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned INC   = 1
) (
   input logic                clk,
   input logic                rst,
   pc_counter_stack_if.slave  bus
);
   localparam int unsigned LVLW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] pc;
   logic [LVLW-1:0]  lvl;
   logic             wrap_q;
   logic             ovf_q;
   logic             unf_q;
   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] top;
   logic             full;
   logic             empty;

   // Extra carry bit captures the modulo-2^WIDTH wrap of the increment.
   assign sum   = {1'b0, pc} + (WIDTH + 1)'(INC);
   assign full  = (lvl == LVLW'(DEPTH));
   assign empty = (lvl == '0);

   // Entry selection by comparison keeps index widths exact for any DEPTH.
   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (lvl == LVLW'(i + 1)) top = stack[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= '0;
         lvl    <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (bus.ret) begin
            if (!empty) begin
               pc  <= top;
               lvl <= lvl - LVLW'(1);
            end else begin
               unf_q <= 1'b1;
            end
         end else if (bus.call) begin
            if (!full) begin
               pc  <= bus.cnt_in;
               lvl <= lvl + LVLW'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (bus.load) begin
            pc <= bus.cnt_in;
         end else if (bus.enab) begin
            pc     <= sum[WIDTH-1:0];
            wrap_q <= sum[WIDTH];
         end
      end
   end

   // Stack storage has no reset; contents are only meaningful below lvl.
   always_ff @(posedge clk) begin
      if (!rst && !bus.ret && bus.call && !full) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (lvl == LVLW'(i)) stack[i] <= sum[WIDTH-1:0];
         end
      end
   end

   assign bus.cnt_out  = pc;
   assign bus.sp_level = lvl;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.wrapped  = wrap_q;
   assign bus.ovf_err  = ovf_q;
   assign bus.unf_err  = unf_q;
endmodule

// File: tb/tb_pc_counter_stack.sv
// Directed bench for pc_counter_stack: INC=1 instance for the main scenarios,
// INC=4 instance for the step parameter.
module tb_pc_counter_stack;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pc_counter_stack_if #(.WIDTH(5), .DEPTH(4)) bus1 ();
   pc_counter_stack_if #(.WIDTH(5), .DEPTH(4)) bus4 ();

   pc_counter_stack #(.WIDTH(5), .DEPTH(4), .INC(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );
   pc_counter_stack #(.WIDTH(5), .DEPTH(4), .INC(4)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic e, input logic l,
                      input logic c, input logic t, input logic [4:0] d);
      rst = r; bus1.enab = e; bus1.load = l; bus1.call = c; bus1.ret = t; bus1.cnt_in = d;
   endtask

   task automatic drv4(input logic e, input logic l, input logic c,
                       input logic t, input logic [4:0] d);
      bus4.enab = e; bus4.load = l; bus4.call = c; bus4.ret = t; bus4.cnt_in = d;
   endtask

   task automatic test_reset();
      drv(1, 1, 1, 1, 1, 5'd9); drv4(0, 0, 0, 0, 5'd0); tick();
      checks++; if (bus1.cnt_out !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus1.cnt_out); end
      checks++; if (bus1.sp_level !== 3'd0) begin errors++; $display("FAIL reset_lvl got %0d want 0", bus1.sp_level); end
      checks++; if ({bus1.full, bus1.empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty got %b want 01", {bus1.full, bus1.empty}); end
      checks++; if ({bus1.wrapped, bus1.ovf_err, bus1.unf_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus1.wrapped, bus1.ovf_err, bus1.unf_err}); end
   endtask

   task automatic test_increment_wrap();
      drv(0, 1, 0, 0, 0, 5'd0);
      for (int i = 1; i <= 33; i++) begin
         tick();
         checks++; if (bus1.cnt_out !== 5'(i % 32)) begin errors++; $display("FAIL inc_cnt[%0d] got %0d want %0d", i, bus1.cnt_out, i % 32); end
         checks++; if (bus1.wrapped !== (i == 32)) begin errors++; $display("FAIL inc_wrapped[%0d] got %b want %b", i, bus1.wrapped, i == 32); end
      end
      drv(0, 0, 1, 0, 0, 5'd7); tick();
      checks++; if (bus1.cnt_out !== 5'd7) begin errors++; $display("FAIL load7 got %0d want 7", bus1.cnt_out); end
   endtask

   task automatic test_nested_call();
      drv(0, 0, 1, 0, 0, 5'd3); tick();
      drv(0, 0, 0, 1, 0, 5'd20); tick();
      checks++; if (bus1.cnt_out !== 5'd20) begin errors++; $display("FAIL call1_cnt got %0d want 20", bus1.cnt_out); end
      drv(0, 0, 0, 1, 0, 5'd10); tick();
      checks++; if (bus1.cnt_out !== 5'd10) begin errors++; $display("FAIL call2_cnt got %0d want 10", bus1.cnt_out); end
      checks++; if (bus1.sp_level !== 3'd2) begin errors++; $display("FAIL call2_lvl got %0d want 2", bus1.sp_level); end
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      checks++; if (bus1.cnt_out !== 5'd21) begin errors++; $display("FAIL ret1_cnt got %0d want 21", bus1.cnt_out); end
      checks++; if (bus1.sp_level !== 3'd1) begin errors++; $display("FAIL ret1_lvl got %0d want 1", bus1.sp_level); end
      tick();
      checks++; if (bus1.cnt_out !== 5'd4) begin errors++; $display("FAIL ret2_cnt got %0d want 4", bus1.cnt_out); end
      checks++; if (bus1.empty !== 1'b1) begin errors++; $display("FAIL ret2_empty got %b want 1", bus1.empty); end
      checks++; if (bus1.unf_err !== 1'b0) begin errors++; $display("FAIL ret2_unf got %b want 0", bus1.unf_err); end
   endtask

   task automatic test_overflow();
      drv(1, 0, 0, 0, 0, 5'd0); tick();
      drv(0, 0, 0, 1, 0, 5'd9);
      for (int i = 0; i < 4; i++) tick();
      checks++; if ({bus1.full, bus1.sp_level} !== 4'b1_100) begin errors++; $display("FAIL ovf_full got full=%b lvl=%0d want full=1 lvl=4", bus1.full, bus1.sp_level); end
      checks++; if (bus1.ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", bus1.ovf_err); end
      drv(0, 0, 0, 1, 0, 5'd15); tick();
      checks++; if (bus1.cnt_out !== 5'd9) begin errors++; $display("FAIL ovf_cnt got %0d want 9", bus1.cnt_out); end
      checks++; if (bus1.sp_level !== 3'd4) begin errors++; $display("FAIL ovf_lvl got %0d want 4", bus1.sp_level); end
      checks++; if (bus1.ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", bus1.ovf_err); end
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      checks++; if (bus1.cnt_out !== 5'd10) begin errors++; $display("FAIL ovf_pop got %0d want 10", bus1.cnt_out); end
      drv(0, 1, 0, 0, 0, 5'd0); tick();
      checks++; if (bus1.ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus1.ovf_err); end
   endtask

   task automatic test_underflow_priority();
      drv(1, 0, 0, 0, 0, 5'd0); tick();
      drv(0, 0, 1, 0, 0, 5'd13); tick();
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      checks++; if (bus1.cnt_out !== 5'd13) begin errors++; $display("FAIL unf_cnt got %0d want 13", bus1.cnt_out); end
      checks++; if ({bus1.unf_err, bus1.sp_level} !== 4'b1_000) begin errors++; $display("FAIL unf_err got unf=%b lvl=%0d want unf=1 lvl=0", bus1.unf_err, bus1.sp_level); end
      drv(0, 0, 1, 0, 0, 5'd5); tick();
      drv(0, 0, 0, 1, 0, 5'd20); tick();
      drv(0, 1, 1, 1, 1, 5'd25); tick();
      checks++; if (bus1.cnt_out !== 5'd6) begin errors++; $display("FAIL callret_cnt got %0d want 6", bus1.cnt_out); end
      checks++; if (bus1.sp_level !== 3'd0) begin errors++; $display("FAIL callret_lvl got %0d want 0", bus1.sp_level); end
      checks++; if (bus1.ovf_err !== 1'b0) begin errors++; $display("FAIL callret_ovf got %b want 0", bus1.ovf_err); end
      drv(0, 0, 1, 0, 0, 5'd31); tick();
      drv(0, 1, 1, 0, 0, 5'd12); tick();
      checks++; if (bus1.cnt_out !== 5'd12) begin errors++; $display("FAIL loadenab_cnt got %0d want 12", bus1.cnt_out); end
      checks++; if (bus1.wrapped !== 1'b0) begin errors++; $display("FAIL loadenab_wrap got %b want 0", bus1.wrapped); end
      drv(0, 0, 0, 0, 0, 5'd0); tick();
      checks++; if (bus1.cnt_out !== 5'd12) begin errors++; $display("FAIL idle_hold got %0d want 12", bus1.cnt_out); end
   endtask

   task automatic test_reset_mid();
      drv(1, 0, 0, 0, 0, 5'd0); tick();
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      drv(0, 0, 0, 1, 0, 5'd2);
      for (int i = 0; i < 5; i++) tick();
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      checks++; if ({bus1.sp_level, bus1.ovf_err, bus1.unf_err} !== 5'b011_11) begin errors++; $display("FAIL mid_setup got lvl=%0d ovf=%b unf=%b want lvl=3 ovf=1 unf=1", bus1.sp_level, bus1.ovf_err, bus1.unf_err); end
      drv(1, 0, 0, 1, 0, 5'd17); tick();
      checks++; if (bus1.cnt_out !== 5'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", bus1.cnt_out); end
      checks++; if ({bus1.sp_level, bus1.empty, bus1.full} !== 5'b000_10) begin errors++; $display("FAIL mid_lvl got lvl=%0d empty=%b full=%b want 0/1/0", bus1.sp_level, bus1.empty, bus1.full); end
      checks++; if ({bus1.wrapped, bus1.ovf_err, bus1.unf_err} !== 3'b000) begin errors++; $display("FAIL mid_flags got %b want 000", {bus1.wrapped, bus1.ovf_err, bus1.unf_err}); end
      drv(0, 0, 0, 0, 1, 5'd0); tick();
      checks++; if ({bus1.unf_err, bus1.cnt_out} !== 6'b1_00000) begin errors++; $display("FAIL mid_ret got unf=%b cnt=%0d want unf=1 cnt=0", bus1.unf_err, bus1.cnt_out); end
   endtask

   task automatic test_step_inc4();
      drv(1, 0, 0, 0, 0, 5'd0); drv4(0, 0, 0, 0, 5'd0); tick();
      rst = 1'b0;
      drv4(0, 1, 0, 0, 5'd28); tick();
      drv4(1, 0, 0, 0, 5'd0); tick();
      checks++; if (bus4.cnt_out !== 5'd0) begin errors++; $display("FAIL inc4_cnt got %0d want 0", bus4.cnt_out); end
      checks++; if (bus4.wrapped !== 1'b1) begin errors++; $display("FAIL inc4_wrap got %b want 1", bus4.wrapped); end
      tick();
      checks++; if ({bus4.cnt_out, bus4.wrapped} !== 6'b00100_0) begin errors++; $display("FAIL inc4_next got cnt=%0d wrap=%b want cnt=4 wrap=0", bus4.cnt_out, bus4.wrapped); end
      drv4(0, 1, 0, 0, 5'd5); tick();
      drv4(0, 0, 1, 0, 5'd16); tick();
      checks++; if ({bus4.cnt_out, bus4.sp_level} !== 8'b10000_001) begin errors++; $display("FAIL inc4_call got cnt=%0d lvl=%0d want 16/1", bus4.cnt_out, bus4.sp_level); end
      drv4(0, 0, 0, 1, 5'd0); tick();
      checks++; if (bus4.cnt_out !== 5'd9) begin errors++; $display("FAIL inc4_ret got %0d want 9", bus4.cnt_out); end
      drv4(0, 0, 0, 0, 5'd0);
   endtask

   initial begin
      drv(0, 0, 0, 0, 0, 5'd0);
      drv4(0, 0, 0, 0, 5'd0);
      test_reset();
      test_increment_wrap();
      test_nested_call();
      test_overflow();
      test_underflow_priority();
      test_reset_mid();
      test_step_inc4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
